gpio_pattern_seq: RTL and testbench

GPIO_PATTERN_SEQ -- requirements
Module: gpio_pattern_seq

---
 rtl/gpio_pattern_seq.sv | 126 ++++++++++++
 tb/tb_gpio_pattern_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_seq.sv
// gpio_pattern_seq: replays a register-programmed pattern table onto a GPIO block bus shared with CPU pass-through
module gpio_pattern_seq #(
  parameter int TOTAL_GPIOS = 8,
  parameter int DEPTH = 4
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        cg_valid,
  input  logic [3:0]  cg_addr,
  input  logic [31:0] cg_wdata,
  input  logic [3:0]  cg_wstrb,
  output logic        cg_ready,
  output logic [31:0] cg_rdata,
  output logic        gm_valid,
  output logic [3:0]  gm_addr,
  output logic [31:0] gm_wdata,
  output logic [3:0]  gm_wstrb,
  input  logic        gm_ready,
  input  logic [31:0] gm_rdata,
  output logic        busy,
  output logic        done_irq
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [2:0] DEPTH_W = 3'(DEPTH);
  state_t state, state_n;
  logic loop_r, done_r, done_set;
  logic [23:0] period_r, cnt, cnt_n, ep;
  logic [2:0] count_r, ec;
  logic [1:0] idx, idx_n;
  logic [TOTAL_GPIOS-1:0] pattern [4];
  logic wr, ctrl_wr, start, stop, clr, owned, hs, last;
  logic unused;
  assign unused = ^mem_wdata;
  assign wr = mem_valid && mem_wstrb == 4'hF;
  assign ctrl_wr = wr && mem_addr == 4'd0;
  assign start = ctrl_wr && mem_wdata[0];
  assign stop = ctrl_wr && mem_wdata[1];
  assign clr = ctrl_wr && mem_wdata[3];
  assign ec = count_r > DEPTH_W ? DEPTH_W : count_r;
  assign ep = period_r == '0 ? 24'd1 : period_r;
  assign owned = state == REQ && !cg_valid;
  assign hs = owned && gm_ready;
  assign last = {1'b0, idx} == ec - 3'd1;
  assign busy = state != IDLE;
  assign mem_ready = mem_valid;
  assign gm_valid = cg_valid || owned;
  assign gm_addr = cg_valid ? cg_addr : 4'h0;
  assign gm_wdata = cg_valid ? cg_wdata : owned ? 32'(pattern[idx]) : '0;
  assign gm_wstrb = cg_valid ? cg_wstrb : owned ? 4'hF : 4'h0;
  assign cg_ready = cg_valid && gm_ready;
  assign cg_rdata = cg_valid ? gm_rdata : '0;
  always_comb begin
    mem_rdata = '0;
    if (mem_valid)
      mem_rdata = mem_addr == 4'd0 ? {29'b0, loop_r, 2'b0} :
                  mem_addr == 4'd1 ? {8'b0, period_r} :
                  mem_addr == 4'd2 ? {29'b0, count_r} :
                  mem_addr == 4'd3 ? {28'b0, idx, done_r, busy} :
                  mem_addr[3:2] == 2'b01 ? 32'(pattern[mem_addr[1:0]]) : '0;
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    done_set = 1'b0;
    if (stop) begin
      state_n = IDLE;
      idx_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && ec != '0) begin
            state_n = REQ;
            idx_n = '0;
          end
          done_set = start && ec == '0;
        end
        REQ: begin
          if (hs && last && !loop_r) begin
            state_n = IDLE;
            idx_n = '0;
            done_set = 1'b1;
          end else if (hs) begin
            state_n = WAIT;
            idx_n = last ? 2'd0 : idx + 2'd1;
            cnt_n = ep;
          end
        end
        WAIT: begin
          state_n = cnt == 24'd1 ? REQ : WAIT;
          cnt_n = cnt == 24'd1 ? cnt : cnt - 24'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      loop_r <= 1'b0;
      period_r <= '0;
      count_r <= '0;
      done_r <= 1'b0;
      done_irq <= 1'b0;
      for (int i = 0; i < 4; i++) pattern[i] <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      done_irq <= done_set;
      done_r <= done_set || (done_r && !clr);
      if (ctrl_wr) loop_r <= mem_wdata[2];
      if (wr && mem_addr == 4'd1) period_r <= mem_wdata[23:0];
      if (wr && mem_addr == 4'd2) count_r <= mem_wdata[2:0];
      if (wr && mem_addr[3:2] == 2'b01) pattern[mem_addr[1:0]] <= mem_wdata[TOTAL_GPIOS-1:0];
    end
  end
endmodule

// File: tb/tb_gpio_pattern_seq.sv
// tb_gpio_pattern_seq: register vectors plus scoreboarded GPIO write sequences for gpio_pattern_seq
module tb_gpio_pattern_seq;
  logic mem_clk = 1'b0, rst_n = 1'b0;
  logic mem_valid = 1'b0, cg_valid = 1'b0, gm_ready = 1'b0;
  logic [3:0] mem_addr = '0, mem_wstrb = '0, cg_addr = '0, cg_wstrb = '0;
  logic [31:0] mem_wdata = '0, cg_wdata = '0, gm_rdata = '0;
  logic mem_ready, cg_ready, gm_valid, busy, done_irq;
  logic [31:0] mem_rdata, cg_rdata, gm_wdata;
  logic [3:0] gm_addr, gm_wstrb;
  int n_chk = 0, n_pass = 0, cyc = 0, irq_cnt = 0;
  logic [31:0] exp_q [$];
  int hs_cyc [$];
  typedef struct {
    logic [3:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [12];

  gpio_pattern_seq dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cg_valid(cg_valid), .cg_addr(cg_addr), .cg_wdata(cg_wdata), .cg_wstrb(cg_wstrb),
    .cg_ready(cg_ready), .cg_rdata(cg_rdata),
    .gm_valid(gm_valid), .gm_addr(gm_addr), .gm_wdata(gm_wdata), .gm_wstrb(gm_wstrb),
    .gm_ready(gm_ready), .gm_rdata(gm_rdata),
    .busy(busy), .done_irq(done_irq)
  );

  always #5 mem_clk = ~mem_clk;
  always @(posedge mem_clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge mem_clk) begin
    if (done_irq) irq_cnt++;
    if (rst_n && gm_valid && gm_ready && !cg_valid) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_hs: got write %0h at cycle %0d, expected none", gm_wdata, cyc);
      end else chk("gm_write", {gm_addr, gm_wstrb, gm_wdata}, {4'h0, 4'hF, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    tick();
    mem_valid = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wstrb = '0;
    #1;
    chk("mem_ready", mem_ready, 1);
    d = mem_rdata;
    mem_valid = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic setup(input logic [7:0] p0, p1, p2, p3, input logic [31:0] count, period);
    wr(4, {24'b0, p0});
    wr(5, {24'b0, p1});
    wr(6, {24'b0, p2});
    wr(7, {24'b0, p3});
    wr(2, count);
    wr(1, period);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0, irq0, drop_cyc, n;
    vt[0]  = '{4'd1, 32'h00ABCDEF, 4'hF, 32'h00ABCDEF};
    vt[1]  = '{4'd1, 32'h12345678, 4'h3, 32'h00ABCDEF};
    vt[2]  = '{4'd1, 32'hFF000003, 4'hF, 32'h00000003};
    vt[3]  = '{4'd2, 32'hFFFFFFFD, 4'hF, 32'h00000005};
    vt[4]  = '{4'd4, 32'h00001234, 4'hF, 32'h00000034};
    vt[5]  = '{4'd7, 32'h00000080, 4'hF, 32'h00000080};
    vt[6]  = '{4'd6, 32'h000000AA, 4'h8, 32'h00000000};
    vt[7]  = '{4'd0, 32'h00000004, 4'hF, 32'h00000004};
    vt[8]  = '{4'd0, 32'h00000000, 4'hF, 32'h00000000};
    vt[9]  = '{4'd9, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[10] = '{4'd3, 32'h0000000F, 4'hF, 32'h00000000};
    vt[11] = '{4'd2, 32'h00000000, 4'hF, 32'h00000000};
    repeat (3) tick();
    chk("rst_gm_valid", gm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", done_irq, 0);
    rd_chk("rst_status", 3, 0);
    rst_n = 1'b1;
    gm_ready = 1'b1;
    tick();
    foreach (vt[i]) begin
      wr(vt[i].addr, vt[i].wdata, vt[i].wstrb);
      rd_chk($sformatf("reg_vec%0d", i), vt[i].addr, vt[i].exp);
    end
    mem_addr = 4'd1;
    #1 chk("rdata_no_valid", mem_rdata, 0);

    setup(8'h01, 8'h02, 8'h04, 8'h08, 4, 3);
    exp_q = '{32'h01, 32'h02, 32'h04, 32'h08};
    hs0 = hs_cyc.size();
    irq0 = irq_cnt;
    wr(0, 32'h1);
    chk("t1_busy", busy, 1);
    wait_idle(100);
    repeat (3) tick();
    chk("t1_hs_count", hs_cyc.size() - hs0, 4);
    for (int k = hs0 + 1; k < hs_cyc.size(); k++) chk("t1_spacing", hs_cyc[k] - hs_cyc[k-1], 4);
    chk("t1_irq_count", irq_cnt - irq0, 1);
    rd_chk("t1_status", 3, 32'h2);

    wr(0, 32'h8);
    rd_chk("clear_done", 3, 0);
    for (int k = 0; k < 10; k++) exp_q.push_back(32'h1 << (k % 4));
    hs0 = hs_cyc.size();
    irq0 = irq_cnt;
    wr(0, 32'h5);
    n = 0;
    while (hs_cyc.size() - hs0 < 10 && n < 200) begin
      tick();
      n++;
    end
    chk("t2_loop_hs", hs_cyc.size() - hs0, 10);
    rd_chk("t2_ctrl_loop", 0, 32'h4);
    wr(0, 32'h2);
    chk("t2_stop_busy", busy, 0);
    repeat (20) tick();
    chk("t2_no_more_hs", hs_cyc.size() - hs0, 10);
    chk("t2_no_irq", irq_cnt - irq0, 0);
    rd_chk("t2_status", 3, 0);
    wr(0, 32'h0);

    setup(8'h11, 8'h22, 8'h00, 8'h00, 2, 3);
    exp_q = '{32'h11, 32'h22};
    hs0 = hs_cyc.size();
    cg_valid = 1'b1;
    cg_addr = 4'd5;
    cg_wstrb = 4'h3;
    cg_wdata = 32'hDEADBEEF;
    wr(0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      gm_ready = (i % 2) == 1;
      gm_rdata = 32'hCAFE0000 + i;
      cg_wdata = 32'h1000 + i;
      #1;
      chk("cg_gm_valid", gm_valid, 1);
      chk("cg_gm_bus", {gm_addr, gm_wstrb, gm_wdata}, {4'd5, 4'h3, 32'h1000 + i});
      chk("cg_ready", cg_ready, (i % 2) == 1);
      chk("cg_rdata", cg_rdata, 32'hCAFE0000 + i);
      chk("cg_busy", busy, 1);
      tick();
    end
    chk("cg_stalled", hs_cyc.size() - hs0, 0);
    cg_valid = 1'b0;
    gm_ready = 1'b1;
    drop_cyc = cyc;
    wait_idle(100);
    chk("cg_first_hs", hs_cyc.size() > hs0 ? hs_cyc[hs0] : -1, drop_cyc);
    chk("cg_hs_count", hs_cyc.size() - hs0, 2);

    wr(2, 0);
    hs0 = hs_cyc.size();
    irq0 = irq_cnt;
    wr(0, 32'h9);
    chk("c0_busy", busy, 0);
    chk("c0_irq_now", done_irq, 1);
    repeat (5) tick();
    chk("c0_irq_count", irq_cnt - irq0, 1);
    chk("c0_no_hs", hs_cyc.size() - hs0, 0);
    rd_chk("c0_set_beats_clear", 3, 32'h2);
    wr(0, 32'h8);
    rd_chk("c0_cleared", 3, 0);
    setup(8'h01, 8'h02, 8'h04, 8'h08, 6, 1);
    exp_q = '{32'h01, 32'h02, 32'h04, 32'h08};
    hs0 = hs_cyc.size();
    wr(0, 32'h1);
    wait_idle(100);
    chk("c6_hs_count", hs_cyc.size() - hs0, 4);

    setup(8'hA1, 8'hB2, 8'hC3, 8'h00, 3, 0);
    exp_q = '{32'hA1, 32'hB2, 32'hC3};
    hs0 = hs_cyc.size();
    wr(0, 32'h1);
    wr(0, 32'h1);
    wait_idle(100);
    chk("p0_hs_count", hs_cyc.size() - hs0, 3);
    for (int k = hs0 + 1; k < hs_cyc.size(); k++) chk("p0_spacing", hs_cyc[k] - hs_cyc[k-1], 2);

    hs0 = hs_cyc.size();
    wr(0, 32'h3);
    chk("startstop_busy", busy, 0);
    repeat (3) tick();
    chk("startstop_no_hs", hs_cyc.size() - hs0, 0);

    setup(8'h01, 8'h02, 8'h04, 8'h08, 4, 10);
    exp_q = '{32'h01};
    hs0 = hs_cyc.size();
    wr(0, 32'h1);
    n = 0;
    while (hs_cyc.size() == hs0 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gm_valid", gm_valid, 0);
    chk("arst_gm_bus", {gm_addr, gm_wstrb, gm_wdata}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_irq", done_irq, 0);
    exp_q.delete();
    @(negedge mem_clk);
    rst_n = 1'b1;
    tick();
    rd_chk("arst_status", 3, 0);
    rd_chk("arst_period", 1, 0);
    repeat (25) tick();
    chk("arst_no_hs", hs_cyc.size() - hs0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
